// File: rtl/sub_bytes_pipe.sv
// Two-stage AES SubBytes / InvSubBytes unit, LANES bytes per beat.
// S-box computed as GF(2^8) inversion plus the FIPS-197 affine maps.
module sub_bytes_pipe #(
  parameter int LANES = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_inv,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]}
         ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] x,
    input logic       inv
  );
    return inv ? gf_inv(aff_inv(x)) : aff_fwd(gf_inv(x));
  endfunction

  logic               s1_valid;
  logic [8*LANES-1:0] s1_data;
  logic               s1_inv;
  logic [TAG_W-1:0]   s1_tag;
  logic               s2_valid;
  logic [8*LANES-1:0] sub_data;
  logic               s2_adv;
  logic               in_fire;

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = reset_n && !flush && (!s1_valid || s2_adv);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign busy      = s1_valid || s2_valid;

  always_comb begin
    sub_data = '0;
    for (int i = 0; i < LANES; i++) begin
      sub_data[8*i +: 8] = sbox(s1_data[8*i +: 8], s1_inv);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_inv   <= 1'b0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      out_data <= '0;
      out_inv  <= 1'b0;
      out_tag  <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        out_data <= sub_data;
        out_inv  <= s1_inv;
        out_tag  <= s1_tag;
      end
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_data  <= in_data;
        s1_inv   <= in_inv;
        s1_tag   <= in_tag;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Bench for sub_bytes_pipe: S-box tables derived by brute-force
// GF(2^8) inversion, streams scored against them.
module tb_sub_bytes_pipe;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_inv = 1'b0;
  logic [3:0]   in_tag = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         out_inv;
  logic [3:0]   out_tag;
  logic         busy;

  logic         w_flush = 1'b0;
  logic         w_in_valid = 1'b0;
  logic         w_in_ready;
  logic [7:0]   w_in_data = '0;
  logic         w_in_inv = 1'b0;
  logic [0:0]   w_in_tag = '0;
  logic         w_out_valid;
  logic         w_out_ready = 1'b1;
  logic [7:0]   w_out_data;
  logic         w_out_inv;
  logic [0:0]   w_out_tag;
  logic         w_busy;

  int checks = 0;
  int fails = 0;

  logic [7:0] sb [256];
  logic [7:0] isb [256];

  logic [127:0] q_d [$];
  bit           q_i [$];
  logic [3:0]   q_t [$];
  logic [127:0] r_d [$];
  bit           r_i [$];
  logic [3:0]   r_t [$];

  always #5 clk = ~clk;

  sub_bytes_pipe #(.LANES(16), .TAG_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_inv(out_inv), .out_tag(out_tag),
    .busy(busy)
  );

  sub_bytes_pipe #(.LANES(1), .TAG_W(1)) dut_w (
    .clk(clk), .reset_n(reset_n), .flush(w_flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_data(w_in_data), .in_inv(w_in_inv), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_data(w_out_data), .out_inv(w_out_inv), .out_tag(w_out_tag),
    .busy(w_busy)
  );

  // Carry-less product then polynomial reduction by x^8+x^4+x^3+x+1
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p ^= 16'(a) << i;
    for (int k = 15; k >= 8; k--)
      if (p[k]) p ^= 16'h011b << (k - 8);
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] v;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      v = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && ref_mul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8]
             ^ v[(i+7)%8] ^ c[i];
      sb[x] = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model_sub(input logic [127:0] d, input bit inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = inv ? isb[d[8*i +: 8]] : sb[d[8*i +: 8]];
    return r;
  endfunction

  // Drives q_* beats, records consumed beats into r_*; no checking here.
  task automatic run_stream(input int slo, input int shi, output int cyc,
                            output bit tmo, output bit saw_low,
                            output int unstable);
    int sent;
    bit fin;
    bit pstall;
    logic [127:0] pd;
    logic [3:0] pt;
    logic pi;
    r_d.delete(); r_i.delete(); r_t.delete();
    sent = 0; cyc = 0; tmo = 0; saw_low = 0; unstable = 0; pstall = 0;
    pd = '0; pt = '0; pi = 0;
    while (r_d.size() < q_d.size()) begin
      if (cyc > 100 + 4 * q_d.size()) begin
        tmo = 1;
        break;
      end
      out_ready = !(cyc >= slo && cyc <= shi);
      if (sent < q_d.size()) begin
        in_valid = 1; in_data = q_d[sent];
        in_inv = q_i[sent]; in_tag = q_t[sent];
      end else begin
        in_valid = 0;
      end
      @(negedge clk);
      if (!in_ready) saw_low = 1;
      if (pstall && (out_data !== pd || out_tag !== pt || out_inv !== pi))
        unstable++;
      fin = in_valid && in_ready;
      if (out_valid && out_ready) begin
        r_d.push_back(out_data); r_i.push_back(out_inv);
        r_t.push_back(out_tag);
      end
      pstall = out_valid && !out_ready;
      pd = out_data; pt = out_tag; pi = out_inv;
      @(posedge clk); #1;
      if (fin) sent++;
      cyc++;
    end
    in_valid = 0;
    out_ready = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got valid=%b busy=%b rdy=%b want 0 0 0",
               out_valid, busy, in_ready);
    end
    checks++;
    if (out_data !== '0 || out_tag !== '0 || out_inv !== 1'b0) begin
      fails++;
      $display("FAIL reset_data: got %h tag %h inv %b want zeros",
               out_data, out_tag, out_inv);
    end
    #2 reset_n = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_forward_vectors();
    logic [7:0] fi [8];
    logic [7:0] fo [8];
    logic [127:0] d;
    logic [127:0] e;
    fi = '{8'h19, 8'h45, 8'h29, 8'h01, 8'hef, 8'ha4, 8'h7b, 8'h33};
    fo = '{8'hd4, 8'h6e, 8'ha5, 8'h7c, 8'hdf, 8'h49, 8'h21, 8'hc3};
    d = '0;
    e = {16{8'h63}};
    for (int i = 0; i < 8; i++) begin
      d[8*i +: 8] = fi[i];
      e[8*i +: 8] = fo[i];
    end
    out_ready = 1; in_valid = 1; in_data = d; in_inv = 0; in_tag = 4'h5;
    @(posedge clk); #1;
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL fwd_latency_early: out_valid %b want 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== e || out_tag !== 4'h5) begin
      fails++;
      $display("FAIL fwd_vectors: got v=%b %h tag %h want 1 %h 5",
               out_valid, out_data, out_tag, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_inverse_vectors();
    logic [7:0] vi [5];
    logic [7:0] vo [5];
    logic [127:0] d;
    logic [127:0] e;
    vi = '{8'hd4, 8'h6e, 8'ha5, 8'h63, 8'h52};
    vo = '{8'h19, 8'h45, 8'h29, 8'h00, 8'h48};
    d = '0;
    e = {16{8'h52}};
    for (int i = 0; i < 5; i++) begin
      d[8*i +: 8] = vi[i];
      e[8*i +: 8] = vo[i];
    end
    in_valid = 1; in_data = d; in_inv = 1; in_tag = 4'ha;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== e || out_inv !== 1'b1) begin
      fails++;
      $display("FAIL inv_vectors: got v=%b %h inv %b want 1 %h 1",
               out_valid, out_data, out_inv, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep_round_trip();
    logic [127:0] orig [16];
    int cyc, unst;
    bit tmo, low;
    int bad;
    q_d.delete(); q_i.delete(); q_t.delete();
    for (int b = 0; b < 16; b++) begin
      for (int l = 0; l < 16; l++) orig[b][8*l +: 8] = 8'(b * 16 + l);
      q_d.push_back(orig[b]); q_i.push_back(0);
      q_t.push_back(4'($urandom));
    end
    run_stream(-1, -1, cyc, tmo, low, unst);
    checks++;
    if (tmo || r_d.size() != 16) begin
      fails++;
      $display("FAIL sweep_fwd_count: got %0d beats tmo=%b want 16",
               r_d.size(), tmo);
    end
    bad = 0;
    for (int b = 0; b < r_d.size() && b < 16; b++)
      if (r_d[b] !== model_sub(orig[b], 0) || r_t[b] !== q_t[b]) bad++;
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL sweep_fwd_data: got %0d bad beats want 0", bad);
    end
    q_d.delete(); q_i.delete();
    for (int b = 0; b < r_d.size(); b++) begin
      q_d.push_back(r_d[b]); q_i.push_back(1);
    end
    run_stream(-1, -1, cyc, tmo, low, unst);
    bad = 0;
    for (int b = 0; b < 16; b++)
      if (b >= r_d.size() || r_d[b] !== orig[b]) bad++;
    checks++;
    if (tmo || bad != 0) begin
      fails++;
      $display("FAIL sweep_identity: got %0d bad beats tmo=%b want 0",
               bad, tmo);
    end
  endtask

  task automatic test_alternating_mode();
    int cyc, unst, bad;
    bit tmo, low;
    q_d.delete(); q_i.delete(); q_t.delete();
    for (int b = 0; b < 20; b++) begin
      q_d.push_back({$urandom, $urandom, $urandom, $urandom});
      q_i.push_back(b[0]); q_t.push_back(4'(b));
    end
    run_stream(-1, -1, cyc, tmo, low, unst);
    bad = 0;
    for (int b = 0; b < 20; b++)
      if (b >= r_d.size() || r_i[b] !== q_i[b]
          || r_d[b] !== model_sub(q_d[b], q_i[b]) || r_t[b] !== q_t[b])
        bad++;
    checks++;
    if (tmo || bad != 0) begin
      fails++;
      $display("FAIL alt_mode: got %0d bad beats tmo=%b want 0", bad, tmo);
    end
    checks++;
    if (low || cyc != 22) begin
      fails++;
      $display("FAIL alt_throughput: got %0d cycles ready_low=%b want 22 0",
               cyc, low);
    end
  endtask

  task automatic test_backpressure();
    int cyc, unst, bad;
    bit tmo, low;
    q_d.delete(); q_i.delete(); q_t.delete();
    for (int b = 0; b < 10; b++) begin
      q_d.push_back({$urandom, $urandom, $urandom, $urandom});
      q_i.push_back($urandom_range(0, 1)); q_t.push_back(4'(b));
    end
    run_stream(3, 6, cyc, tmo, low, unst);
    checks++;
    if (!low) begin
      fails++;
      $display("FAIL bp_ready_low: got in_ready never low want low");
    end
    checks++;
    if (unst != 0) begin
      fails++;
      $display("FAIL bp_stable: got %0d changes during stall want 0", unst);
    end
    bad = 0;
    for (int b = 0; b < 10; b++)
      if (b >= r_d.size() || r_t[b] !== 4'(b)
          || r_d[b] !== model_sub(q_d[b], q_i[b]))
        bad++;
    checks++;
    if (tmo || r_d.size() != 10 || bad != 0) begin
      fails++;
      $display("FAIL bp_order: got %0d beats %0d bad tmo=%b want 10 0",
               r_d.size(), bad, tmo);
    end
  endtask

  task automatic test_flush();
    logic [127:0] d;
    out_ready = 0;
    in_valid = 1; in_data = {4{$urandom}}; in_inv = 0; in_tag = 4'h1;
    @(posedge clk); #1;
    in_data = {4{$urandom}}; in_tag = 4'h2;
    @(posedge clk); #1;
    flush = 1; in_data = {4{$urandom}}; in_tag = 4'h3;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL flush_ready: got rdy=%b busy=%b want 0 1",
               in_ready, busy);
    end
    @(posedge clk); #1;
    flush = 0; in_valid = 0; out_ready = 1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL flush_clear: got v=%b busy=%b want 0 0",
               out_valid, busy);
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1; in_data = d; in_inv = 1; in_tag = 4'h7;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'h7
        || out_data !== model_sub(d, 1)) begin
      fails++;
      $display("FAIL flush_after: got v=%b tag %h %h want 1 7 %h",
               out_valid, out_tag, out_data, model_sub(d, 1));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_stream();
    out_ready = 0;
    in_valid = 1; in_data = {4{$urandom}}; in_tag = 4'h9;
    @(posedge clk); #1;
    in_data = {4{$urandom}}; in_tag = 4'hb;
    @(posedge clk); #1;
    in_valid = 0;
    #3 reset_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0
        || out_tag !== '0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: got v=%b busy=%b rdy=%b %h tag %h want 0s",
               out_valid, busy, in_ready, out_data, out_tag);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_hold: got in_ready %b want 0", in_ready);
    end
    #2 reset_n = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_release: got rdy=%b v=%b want 1 0",
               in_ready, out_valid);
    end
    out_ready = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_width_one_lane();
    logic [7:0] vi [3];
    logic [7:0] vo [3];
    vi = '{8'h00, 8'hff, 8'h53};
    vo = '{8'h63, 8'h16, 8'hed};
    w_out_ready = 1;
    for (int j = 0; j < 5; j++) begin
      if (j < 3) begin
        w_in_valid = 1; w_in_data = vi[j]; w_in_tag = 1'(j);
      end else begin
        w_in_valid = 0;
      end
      @(negedge clk);
      if (j < 3) begin
        checks++;
        if (w_in_ready !== 1'b1) begin
          fails++;
          $display("FAIL w1_ready[%0d]: got %b want 1", j, w_in_ready);
        end
      end
      if (j >= 2) begin
        checks++;
        if (w_out_valid !== 1'b1 || w_out_data !== vo[j-2]
            || w_out_tag !== 1'(j-2)) begin
          fails++;
          $display("FAIL w1_out[%0d]: got v=%b %h tag %b want 1 %h %b",
                   j - 2, w_out_valid, w_out_data, w_out_tag,
                   vo[j-2], 1'(j-2));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_forward_vectors();
    test_inverse_vectors();
    test_sweep_round_trip();
    test_alternating_mode();
    test_backpressure();
    test_flush();
    test_reset_mid_stream();
    test_width_one_lane();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/sub_bytes_pipe.md
# sub_bytes_pipe

Parametrised, pipelined AES byte-substitution unit: applies the FIPS-197 S-box (forward) or inverse S-box to LANES bytes per beat, selected per beat by a mode bit. It is the SubBytes/InvSubBytes stage of the round datapath and replaces single-byte combinational lookup. A valid/ready handshake on both sides provides backpressure, and a 2-entry pipeline sustains one beat per cycle. A sideband tag travels with each beat.

## Interface
- LANES, 16, bytes substituted per beat (1..16)
- TAG_W, 4, width of sideband tag carried with each beat (≥1)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all in-flight beats
- in_valid  in  1  input beat present
- in_ready  out  1  unit can accept a beat this cycle
- in_data  in  8*LANES  lane i = in_data[8i+7:8i]
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box
- in_tag  in  TAG_W  sideband, returned unchanged
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accepts beat
- out_data  out  8*LANES  substituted bytes, same lane order
- out_inv  out  1  mode of the beat on out_data
- out_tag  out  TAG_W  tag of the beat on out_data
- busy  out  1  any stage holds a valid beat

## Operation
- Two stages: S1 (input register: data, inv, tag, valid) and S2 (output register: substituted data, inv, tag, valid). S2 drives the out_* ports directly.
- Substitution is done combinationally between S1 and S2, one S-box per lane. Each lane is independent and chooses forward or inverse from S1's inv bit.
- S-box values follow FIPS-197 exactly. The implementation may use a table or GF(2^8) inversion plus the affine map. Forward and inverse must be exact inverses for all 256 values.
- Handshakes:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
- s2_adv = !s2_valid || out_ready.
- in_ready = reset_n && !flush && (!s1_valid || s2_adv). It is combinational from state, flush and out_ready, and never depends on in_valid.
- On each edge, unless flush:
  - If s2_adv: S2 loads substitute(S1) and s2_valid <= s1_valid.
  - If input transfer: S1 loads the input and s1_valid <= 1.
  - Otherwise, if s2_adv: s1_valid <= 0.
- Stall: while out_valid && !out_ready, out_data, out_inv and out_tag stay stable, and S1 holds.
  - The pipeline holds at most 2 beats.
  - in_ready = 0 only when both stages are valid and output is stalled.
- Flush: at the edge with flush = 1, s1_valid <= 0 and s2_valid <= 0. No input is accepted, since in_ready = 0. A beat presented during flush is dropped and must be re-presented. Flush has priority over all simultaneous handshakes.
- busy = s1_valid || s2_valid.
- Data registers need not be cleared on flush. Only valids are cleared.
- Beats exit in acceptance order. Nothing is reordered or duplicated, and no beat is lost except by flush or reset.

## Timing
- Reset (reset_n low, asynchronous):
  - s1_valid = s2_valid = 0, out_valid = 0, busy = 0.
  - out_data = 0, out_inv = 0, out_tag = 0.
  - in_ready = 0 while reset_n is low.
- First cycle after reset_n rises: in_ready = 1 (if flush = 0).
- Latency:
  - A beat accepted at edge k appears on out_* with out_valid = 1 after edge k+1, i.e. 2 cycles input-to-output.
  - It is consumed at the first edge ≥ k+2 where out_ready = 1.
- Throughput: 1 beat/cycle with out_ready held high, with in_ready constantly 1.
- Simultaneous output consume and input accept with both stages full: legal. S2 takes S1 and S1 takes the new beat in the same edge.
- Reset asserted mid-stream discards all beats immediately (asynchronously). There is no partial output.

## Test plan
- Forward vectors, LANES = 16, in_inv = 0, out_ready = 1: the following bytes in lanes 0..7, with lanes 8..15 = 00, produce the listed outputs 2 cycles after acceptance, and upper lanes give 63.
  - Inputs 19,45,29,01,ef,a4,7b,33.
  - Outputs d4,6e,a5,7c,df,49,21,c3.
- Inverse and round trip:
  - in_inv = 1 on d4,6e,a5,63,52 gives 19,45,29,00,48.
  - Sweeping all 256 values forward then inverse returns identity.
  - out_inv tracks the mode per beat when it alternates every cycle.
- Backpressure:
  - Stream tags 0..9 back-to-back with out_ready = 0 for cycles 3–6. in_ready falls when 2 beats are held, and out_data/out_tag stay stable during the stall.
  - All 10 beats emerge in order with no loss or duplication.
- Flush: with 2 beats in flight and in_valid = 1, assert flush for 1 cycle.
  - That cycle in_ready = 0.
  - Next cycle out_valid = 0 and busy = 0.
  - A subsequent beat emerges normally 2 cycles later.
- Reset mid-stream: drop reset_n asynchronously (between clock edges) with both stages full.
  - out_valid, out_data, out_tag and busy go to 0 immediately.
  - in_ready = 0 until reset_n rises, then 1.
- Width parameter: LANES = 1, TAG_W = 1. Sequence 00,ff,53 (forward) gives 63,16,ed with correct tags at full throughput.
